// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
// Shared definitions for the CPU_CORE pipeline stage registers:
//   - occupancy state encoding (EMPTY, BUSY, FULL)
//   - payload bundle widths for each stage boundary
//   - reset level (synchronous, active low)
package pipe_stage_reg_pkg;

    // Occupancy of a stage: EMPTY, main held, or main and skid held.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

    // ID/EX bundle: opcode + func3 + func7 + pc + rd_en + rd_addr + imm + rs1 + rs2
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNC3_W   = 3;
    localparam int unsigned FUNC7_W   = 7;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned RD_ADDR_W = 5;

    localparam int unsigned ID_EX_W = OPCODE_W + FUNC3_W + FUNC7_W + XLEN + 1 + RD_ADDR_W
                                      + XLEN + XLEN + XLEN;
    // IF/ID: pc + instruction word
    localparam int unsigned IF_ID_W  = XLEN + XLEN;
    // EX/MEM: alu result + store data + rd_en + rd_addr + func3 + opcode
    localparam int unsigned EX_MEM_W = XLEN + XLEN + 1 + RD_ADDR_W + FUNC3_W + OPCODE_W;
    // MEM/WB: writeback value + rd_en + rd_addr
    localparam int unsigned MEM_WB_W = XLEN + 1 + RD_ADDR_W;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/pipe_stage_reg_stall_counter.sv
// pipe_stall_counter
// Saturating up-counter used to measure backpressure cycles.
// Ports:
//   clk  in   clock
//   clr  in   synchronous clear (highest priority)
//   en   in   count enable; the count sticks at all-ones
//   cnt  out  current count
module pipe_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Handshaked (valid/ready) pipeline stage register carrying an opaque payload between two
// CPU_CORE stages, with synchronous flush and a saturating backpressure counter.
// Build option: define PIPE_SKID_EN to add a skid entry so in_ready comes straight from a
// register; otherwise in_ready = out_ready || !out_valid (combinational).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   flush      in   synchronous flush, discards all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept in_data this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts out_data
//   out_data   out  oldest held payload
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q;
    logic [DATA_W-1:0] main_q;
    logic              out_valid_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              clear;

    assign clear     = (rst == RST_ACTIVE) || flush;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic              skid_valid_q;

    // Registered ready: the stage only refuses input once the skid entry is occupied.
    assign in_ready = !skid_valid_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= StEmpty;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_q     <= StBusy;
                        out_valid_q <= 1'b1;
                        main_q      <= in_data;
                    end
                end
                StBusy: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled this cycle: park the new entry behind main.
                        state_q      <= StFull;
                        skid_valid_q <= 1'b1;
                        skid_q       <= in_data;
                    end else if (out_xfer) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        state_q      <= StBusy;
                        skid_valid_q <= 1'b0;
                        main_q       <= skid_q;
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end
`else
    assign in_ready = out_ready || !out_valid_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            main_q      <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_q     <= StBusy;
                        out_valid_q <= 1'b1;
                        main_q      <= in_data;
                    end
                end
                StBusy: begin
                    // in_ready implies out_ready here, so an input transfer always
                    // coincides with an output transfer.
                    if (in_xfer) begin
                        main_q <= in_data;
                    end else if (out_xfer) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    // Flush leaves the counter alone; only reset clears it.
    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk (clk),
        .clr (rst == RST_ACTIVE),
        .en  (out_valid_q && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg; expectations follow PIPE_SKID_EN when it is defined.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 151;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset held two cycles with live input
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('h5A);
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_stall_cnt", DW'(stall_cnt), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        rst      = 1'b1;
        in_valid = 1'b0;

        // Streaming, no bubbles
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            chk("stream_valid", DW'(out_valid), DW'(1));
            chk("stream_data", out_data, DW'(i));
            chk("stream_in_ready", DW'(in_ready), DW'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", DW'(out_valid), DW'(0));
        chk("drain_data_hold", out_data, DW'(4));
        chk("stream_stall_cnt", DW'(stall_cnt), DW'(0));

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hA);
        tick();
        in_data = DW'('hB);
`ifdef PIPE_SKID_EN
        chk("bp_in_ready_busy", DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready_full", DW'(in_ready), DW'(0));
        chk("bp_head_a", out_data, DW'('hA));
        tick();
        tick();
        chk("bp_stall_cnt", DW'(stall_cnt), DW'(3));
        chk("bp_in_ready_held", DW'(in_ready), DW'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_out_a", out_data, DW'('hA));
        tick();
        chk("bp_out_b", out_data, DW'('hB));
        chk("bp_valid_b", DW'(out_valid), DW'(1));
        chk("bp_in_ready_back", DW'(in_ready), DW'(1));
`else
        #1;
        chk("ns_in_ready_low", DW'(in_ready), DW'(0));
        tick();
        tick();
        tick();
        chk("bp_stall_cnt", DW'(stall_cnt), DW'(3));
        chk("bp_head_a", out_data, DW'('hA));
        out_ready = 1'b1;
        #1;
        chk("ns_in_ready_high", DW'(in_ready), DW'(1));
        chk("bp_out_a", out_data, DW'('hA));
        tick();
        in_valid = 1'b0;
        chk("bp_out_b", out_data, DW'('hB));
        chk("bp_valid_b", DW'(out_valid), DW'(1));
`endif
        tick();
        chk("bp_drain_valid", DW'(out_valid), DW'(0));
        chk("bp_drain_hold", out_data, DW'('hB));
        chk("bp_stall_kept", DW'(stall_cnt), DW'(3));

        // Flush with stage loaded and a new entry on the input
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('hA);
        tick();
        in_data = DW'('hB);
        tick();
        in_data = DW'('hC);
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", DW'(out_valid), DW'(0));
        chk("flush_data", out_data, '0);
        chk("flush_stall_cnt", DW'(stall_cnt), DW'(2));
        chk("flush_in_ready", DW'(in_ready), DW'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_c", DW'(out_valid), DW'(0));
        end

        // Saturation of the 4-bit counter
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'('h77);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) chk("sat_mid", DW'(stall_cnt), DW'(10));
        end
        chk("sat_cnt", DW'(stall_cnt), DW'(15));
        chk("sat_data", out_data, DW'('h77));
        chk("sat_valid", DW'(out_valid), DW'(1));

        // Reset mid-operation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_valid", DW'(out_valid), DW'(0));
        chk("midrst_cnt", DW'(stall_cnt), DW'(0));
        chk("midrst_data", out_data, '0);
        chk("midrst_in_ready", DW'(in_ready), DW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
